alarm_challenge_ctrl: RTL and testbench

Parametrised alarm-challenge controller for the wake-up alarm. It counts down a programmable number of seconds from a built-in prescaler, then rings and makes the user solve `NUM_EQ` equations in order. Each equation has its own answer time limit, and wrong answers are counted against a limit; a timeout or too many wrong answers restarts the challenge. It sits between the board switches/keys and the equation generator, which supplies `Expected` for the equation selected by `EqIdx`.

---
 rtl/alarm_challenge_ctrl_if.sv | 30 +++
 rtl/alarm_challenge_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_alarm_challenge_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_challenge_ctrl_if.sv
// Handshake bundle between the board keys/switches, the equation generator
// and the alarm-challenge controller.
interface alarm_challenge_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              Start;
    logic              Go;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] Expected;
    logic [7:0]        SecondsLeft;
    logic [3:0]        EqIdx;
    logic              EqValid;
    logic              Ringing;
    logic              Correct;
    logic              Wrong;
    logic [3:0]        WrongCount;
    logic              Done;

    modport master (
        output Start, Go, DataIn, Expected,
        input  SecondsLeft, EqIdx, EqValid, Ringing, Correct, Wrong,
               WrongCount, Done
    );

    modport slave (
        input  Start, Go, DataIn, Expected,
        output SecondsLeft, EqIdx, EqValid, Ringing, Correct, Wrong,
               WrongCount, Done
    );
endinterface

// File: rtl/alarm_challenge_ctrl.sv
// Alarm-challenge controller: seconds countdown, ringing, then a timed sequence
// of equations that must be answered to silence the alarm.
module alarm_challenge_ctrl #(
    parameter int unsigned NUM_EQ        = 3,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned COUNTDOWN_SEC = 20,
    parameter int unsigned ANSWER_SEC    = 30,
    parameter int unsigned MAX_WRONG     = 3
) (
    input logic                   Clock,
    input logic                   Reset,
    alarm_challenge_ctrl_if.slave bus
);

    localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]    CD_SEC    = 8'(COUNTDOWN_SEC);
    localparam logic [7:0]    ANS_SEC   = 8'(ANSWER_SEC);
    localparam logic [3:0]    LAST_IDX  = 4'(NUM_EQ - 1);
    localparam logic [3:0]    WRONG_LIM = 4'(MAX_WRONG);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNTDOWN,
        ST_RING,
        ST_ASK,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]  sec_q, sec_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  wc_q, wc_d;
    logic        correct_q, correct_d;
    logic        wrong_q, wrong_d;
    logic        eq_valid_q, eq_valid_d;
    logic        ringing_q, ringing_d;
    logic        done_q, done_d;

    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] expected;
    logic              match;
    logic              tick;
    logic              reload;
    logic              timeout;
    logic [3:0]        wc_inc;

    assign data_in  = bus.DataIn;
    assign expected = bus.Expected;
    assign match    = (data_in == expected);
    assign tick     = (presc_q == PRESC_MAX);
    assign wc_inc   = wc_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        idx_d     = idx_q;
        wc_d      = wc_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
        reload    = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_COUNTDOWN;
                    sec_d   = CD_SEC;
                    reload  = 1'b1;
                end
            end

            ST_COUNTDOWN: begin
                if (!bus.Start) begin
                    state_d = ST_IDLE;
                    sec_d   = '0;
                end else if (tick) begin
                    if (sec_q == 8'd1) begin
                        state_d = ST_RING;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q - 8'd1;
                    end
                end
            end

            ST_RING: begin
                if (bus.Go) begin
                    state_d = ST_ASK;
                    idx_d   = '0;
                    wc_d    = '0;
                    sec_d   = ANS_SEC;
                    reload  = 1'b1;
                end
            end

            ST_ASK: begin
                // A correct submission overrides a coincident timeout tick;
                // a wrong one does not, so both restart paths merge below.
                if (bus.Go && match) begin
                    correct_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        sec_d   = '0;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        sec_d  = ANS_SEC;
                        reload = 1'b1;
                    end
                end else begin
                    if (bus.Go) begin
                        wrong_d = 1'b1;
                        wc_d    = wc_inc;
                    end
                    if (tick) begin
                        timeout = (sec_q == 8'd1);
                        sec_d   = sec_q - 8'd1;
                    end
                    if ((bus.Go && (wc_inc == WRONG_LIM)) || timeout) begin
                        state_d = ST_RING;
                        idx_d   = '0;
                        wc_d    = '0;
                        sec_d   = '0;
                    end
                end
            end

            ST_DONE: begin
                sec_d = '0;
                if (!bus.Start) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    wc_d    = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sec_d   = '0;
                idx_d   = '0;
                wc_d    = '0;
            end
        endcase

        eq_valid_d = (state_d == ST_ASK);
        ringing_d  = (state_d == ST_RING) || (state_d == ST_ASK);
        done_d     = (state_d == ST_DONE);
    end

    // Prescaler only runs while a seconds counter is live, and restarts on any
    // state change or reload so every window is a whole number of seconds.
    always_comb begin
        presc_d = '0;
        if ((state_d == state_q) && !reload &&
            ((state_q == ST_COUNTDOWN) || (state_q == ST_ASK)) && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            sec_q      <= '0;
            idx_q      <= '0;
            wc_q       <= '0;
            correct_q  <= 1'b0;
            wrong_q    <= 1'b0;
            eq_valid_q <= 1'b0;
            ringing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            idx_q      <= idx_d;
            wc_q       <= wc_d;
            correct_q  <= correct_d;
            wrong_q    <= wrong_d;
            eq_valid_q <= eq_valid_d;
            ringing_q  <= ringing_d;
            done_q     <= done_d;
        end
    end

    assign bus.SecondsLeft = sec_q;
    assign bus.EqIdx       = idx_q;
    assign bus.EqValid     = eq_valid_q;
    assign bus.Ringing     = ringing_q;
    assign bus.Correct     = correct_q;
    assign bus.Wrong       = wrong_q;
    assign bus.WrongCount  = wc_q;
    assign bus.Done        = done_q;

endmodule

// File: tb/tb_alarm_challenge_ctrl.sv
// Directed bench for alarm_challenge_ctrl with small timing parameters
// (4 cycles/second, 3 s countdown, 2 s answer window, 3 equations, 2 wrongs).
module tb_alarm_challenge_ctrl;

    logic Clock;
    logic Reset;
    int   errors;
    int   checks;

    alarm_challenge_ctrl_if #(.DATA_W(8)) bus ();

    alarm_challenge_ctrl #(
        .NUM_EQ        (3),
        .DATA_W        (8),
        .TICKS_PER_SEC (4),
        .COUNTDOWN_SEC (3),
        .ANSWER_SEC    (2),
        .MAX_WRONG     (2)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sec"},  32'(bus.SecondsLeft), 32'd0);
        chk({tag, "_idx"},  32'(bus.EqIdx),       32'd0);
        chk({tag, "_eqv"},  32'(bus.EqValid),     32'd0);
        chk({tag, "_ring"}, 32'(bus.Ringing),     32'd0);
        chk({tag, "_cor"},  32'(bus.Correct),     32'd0);
        chk({tag, "_wr"},   32'(bus.Wrong),       32'd0);
        chk({tag, "_wc"},   32'(bus.WrongCount),  32'd0);
        chk({tag, "_done"}, 32'(bus.Done),        32'd0);
    endtask

    // From IDLE: arm, wait out the 12-cycle countdown, then Go into ASK.
    task automatic to_ask(input string tag);
        bus.Start = 1'b1;
        step(13);
        chk({tag, "_ring"}, 32'(bus.Ringing), 32'd1);
        bus.Go = 1'b1;
        step(1);
        bus.Go = 1'b0;
        chk({tag, "_eqv"}, 32'(bus.EqValid), 32'd1);
        chk({tag, "_sec"}, 32'(bus.SecondsLeft), 32'd2);
    endtask

    task automatic answer(input logic [7:0] exp_v, input logic [7:0] din);
        bus.Expected = exp_v;
        bus.DataIn   = din;
        bus.Go       = 1'b1;
        step(1);
        bus.Go       = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        Reset        = 1'b1;
        bus.Start    = 1'b0;
        bus.Go       = 1'b0;
        bus.DataIn   = '0;
        bus.Expected = '0;
        step(3);
        chk_all_zero("reset");
        Reset = 1'b0;
        step(1);

        // Go in IDLE does nothing
        bus.Go = 1'b1;
        step(1);
        bus.Go = 1'b0;
        chk_all_zero("idle_go");

        // Countdown 3,2,1 then ring at 12 cycles
        bus.Start = 1'b1;
        step(1);
        chk("cd_entry", 32'(bus.SecondsLeft), 32'd3);
        step(3);
        chk("cd_c3", 32'(bus.SecondsLeft), 32'd3);
        step(1);
        chk("cd_c4", 32'(bus.SecondsLeft), 32'd2);
        step(4);
        chk("cd_c8", 32'(bus.SecondsLeft), 32'd1);
        step(3);
        chk("cd_c11_ring", 32'(bus.Ringing), 32'd0);
        step(1);
        chk("cd_c12_ring", 32'(bus.Ringing), 32'd1);
        chk("cd_c12_sec", 32'(bus.SecondsLeft), 32'd0);
        chk("cd_c12_eqv", 32'(bus.EqValid), 32'd0);

        // Start is ignored while ringing
        bus.Start = 1'b0;
        step(3);
        chk("ring_nostart", 32'(bus.Ringing), 32'd1);
        bus.Start = 1'b1;

        // Solve three equations
        bus.Go = 1'b1;
        step(1);
        bus.Go = 1'b0;
        chk("ask_eqv", 32'(bus.EqValid), 32'd1);
        chk("ask_idx", 32'(bus.EqIdx), 32'd0);
        chk("ask_sec", 32'(bus.SecondsLeft), 32'd2);
        answer(8'h05, 8'h05);
        chk("eq0_cor", 32'(bus.Correct), 32'd1);
        chk("eq0_idx", 32'(bus.EqIdx), 32'd1);
        step(1);
        chk("eq0_cor_low", 32'(bus.Correct), 32'd0);
        answer(8'h11, 8'h11);
        chk("eq1_cor", 32'(bus.Correct), 32'd1);
        chk("eq1_idx", 32'(bus.EqIdx), 32'd2);
        step(1);
        answer(8'hFF, 8'hFF);
        chk("eq2_cor", 32'(bus.Correct), 32'd1);
        chk("eq2_done", 32'(bus.Done), 32'd1);
        chk("eq2_ring", 32'(bus.Ringing), 32'd0);
        chk("eq2_sec", 32'(bus.SecondsLeft), 32'd0);
        step(2);
        chk("done_hold", 32'(bus.Done), 32'd1);
        bus.Start = 1'b0;
        step(1);
        chk_all_zero("done_idle");

        // Abort after 5 cycles of countdown
        bus.Start = 1'b1;
        step(5);
        chk("abort_pre", 32'(bus.SecondsLeft), 32'd2);
        bus.Start = 1'b0;
        step(1);
        chk_all_zero("abort");
        step(12);
        chk("abort_noring", 32'(bus.Ringing), 32'd0);

        // Two back-to-back wrong answers at EqIdx=1
        to_ask("w");
        answer(8'h05, 8'h05);
        chk("w_idx1", 32'(bus.EqIdx), 32'd1);
        bus.Expected = 8'h11;
        bus.DataIn   = 8'h12;
        bus.Go       = 1'b1;
        step(1);
        chk("w1_wrong", 32'(bus.Wrong), 32'd1);
        chk("w1_wc", 32'(bus.WrongCount), 32'd1);
        chk("w1_idx", 32'(bus.EqIdx), 32'd1);
        chk("w1_eqv", 32'(bus.EqValid), 32'd1);
        step(1);
        bus.Go = 1'b0;
        chk("w2_wrong", 32'(bus.Wrong), 32'd1);
        chk("w2_wc", 32'(bus.WrongCount), 32'd0);
        chk("w2_idx", 32'(bus.EqIdx), 32'd0);
        chk("w2_eqv", 32'(bus.EqValid), 32'd0);
        chk("w2_ring", 32'(bus.Ringing), 32'd1);
        chk("w2_sec", 32'(bus.SecondsLeft), 32'd0);

        // Timeout after 8 cycles with no Go
        bus.DataIn   = 8'h00;
        bus.Expected = 8'h05;
        bus.Go = 1'b1;
        step(1);
        bus.Go = 1'b0;
        step(4);
        chk("to_sec1", 32'(bus.SecondsLeft), 32'd1);
        step(3);
        chk("to_c7_eqv", 32'(bus.EqValid), 32'd1);
        step(1);
        chk("to_c8_eqv", 32'(bus.EqValid), 32'd0);
        chk("to_c8_ring", 32'(bus.Ringing), 32'd1);
        chk("to_c8_wrong", 32'(bus.Wrong), 32'd0);
        chk("to_c8_sec", 32'(bus.SecondsLeft), 32'd0);

        // Correct Go on the final tick wins over the timeout
        bus.Go = 1'b1;
        step(1);
        bus.Go = 1'b0;
        step(7);
        answer(8'h05, 8'h05);
        chk("lt_cor", 32'(bus.Correct), 32'd1);
        chk("lt_idx", 32'(bus.EqIdx), 32'd1);
        chk("lt_sec", 32'(bus.SecondsLeft), 32'd2);
        chk("lt_eqv", 32'(bus.EqValid), 32'd1);

        // Wrong Go on the final tick: Wrong pulses and timeout still restarts
        step(7);
        answer(8'h11, 8'h10);
        chk("wt_wrong", 32'(bus.Wrong), 32'd1);
        chk("wt_eqv", 32'(bus.EqValid), 32'd0);
        chk("wt_ring", 32'(bus.Ringing), 32'd1);
        chk("wt_wc", 32'(bus.WrongCount), 32'd0);
        chk("wt_idx", 32'(bus.EqIdx), 32'd0);

        // Asynchronous reset mid-ASK
        bus.Go = 1'b1;
        step(1);
        bus.Go = 1'b0;
        step(2);
        chk("ar_pre_eqv", 32'(bus.EqValid), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk_all_zero("ar");
        bus.Start = 1'b0;
        step(1);
        Reset = 1'b0;
        step(1);
        chk_all_zero("ar_idle");
        bus.Start = 1'b1;
        step(1);
        chk("ar_rearm", 32'(bus.SecondsLeft), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
